cmprs_mb_tile_sequencer: RTL

//  Generates the macroblock tile request stream for one compressed frame. It is the consumer side of the

---
 rtl/cmprs_mb_tile_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cmprs_mb_tile_sequencer.sv
// Macroblock tile request sequencer for one compressed frame (raster order).
// Latency: start at cycle N -> first tile_valid at N+2; 1 tile/clk with tile_ready held high.
// Backpressure: tile_valid/tile_ready handshake, tile outputs held stable while valid & !ready.
//
// Ports:
//   mclk, mrst            clock, asynchronous active-high reset
//   start, abort          frame control pulses (abort wins over everything)
//   converter_type        compressor type, sampled on an accepted start
//   mb_cols_m1/rows_m1    frame size in macroblocks minus 1, sampled on start
//   tile_*                tile request (origin, size, first/last) with valid/ready
//   busy, done, type_err  status: frame in progress, end-of-frame pulse, bad-type pulse
module cmprs_mb_tile_sequencer (
  input  logic        mclk,
  input  logic        mrst,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  converter_type,
  input  logic [9:0]  mb_cols_m1,
  input  logic [11:0] mb_rows_m1,
  output logic        tile_valid,
  input  logic        tile_ready,
  output logic [15:0] tile_x,
  output logic [15:0] tile_y,
  output logic [5:0]  tile_w_m1,
  output logic [5:0]  tile_h_m1,
  output logic        tile_first,
  output logic        tile_last,
  output logic        busy,
  output logic        done,
  output logic        type_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t      state, state_nxt;

  logic [2:0]  type_q;
  logic [9:0]  cols_q;
  logic [11:0] rows_q;
  logic [9:0]  col;
  logic [11:0] row;
  logic [15:0] x_acc;
  logic [15:0] y_acc;
  logic [5:0]  w_m1;
  logic [4:0]  hper;

  logic        type_ok;
  logic        last_col;
  logic        last_row;
  logic        handshake;
  logic        latch_en;
  logic        load_en;
  logic        advance;
  logic        done_set;
  logic        err_set;

  // Types 5 and 6 have no tile geometry.
  always_comb begin
    type_ok = 1'b1;
    if (converter_type == 3'd5 || converter_type == 3'd6) type_ok = 1'b0;
  end

  assign last_col  = (col == cols_q);
  assign last_row  = (row == rows_q);
  assign handshake = tile_valid & tile_ready;

  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tile_valid = 1'b0;
    busy       = 1'b0;
    latch_en   = 1'b0;
    load_en    = 1'b0;
    advance    = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!abort && start) begin
          if (type_ok) begin
            latch_en  = 1'b1;
            state_nxt = S_LOAD;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      S_LOAD: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          load_en   = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy       = 1'b1;
        tile_valid = 1'b1;
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (handshake) begin
          if (last_col && last_row) begin
            done_set  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      type_q   <= 3'd0;
      cols_q   <= 10'd0;
      rows_q   <= 12'd0;
      col      <= 10'd0;
      row      <= 12'd0;
      x_acc    <= 16'd0;
      y_acc    <= 16'd0;
      w_m1     <= 6'd0;
      hper     <= 5'd0;
      done     <= 1'b0;
      type_err <= 1'b0;
    end else begin
      done     <= done_set;
      type_err <= err_set;
      if (latch_en) begin
        type_q <= converter_type;
        cols_q <= mb_cols_m1;
        rows_q <= mb_rows_m1;
      end
      if (load_en) begin
        col   <= 10'd0;
        row   <= 12'd0;
        x_acc <= 16'd0;
        y_acc <= 16'd0;
        case (type_q)
          3'd0:    begin w_m1 <= 6'd17; hper <= 5'd16; end
          3'd1:    begin w_m1 <= 6'd19; hper <= 5'd16; end
          3'd7:    begin w_m1 <= 6'd7;  hper <= 5'd8;  end
          default: begin w_m1 <= 6'd15; hper <= 5'd16; end
        endcase
      end
      // Origins are stepped by accumulation so no multiplier is needed.
      if (advance) begin
        if (last_col) begin
          col   <= 10'd0;
          x_acc <= 16'd0;
          row   <= row + 12'd1;
          y_acc <= y_acc + {11'd0, hper};
        end else begin
          col   <= col + 10'd1;
          x_acc <= x_acc + {11'd0, hper};
        end
      end
    end
  end

  assign tile_x     = x_acc;
  assign tile_y     = y_acc;
  assign tile_w_m1  = w_m1;
  assign tile_h_m1  = w_m1;
  assign tile_first = tile_valid & (col == 10'd0) & (row == 12'd0);
  assign tile_last  = tile_valid & last_col & last_row;

endmodule
